// File: rtl/rf_multiport.sv
// Multiported register file: two write ports and NUM_RD registered read ports.
// A busy scoreboard marks entries that are waiting for a future write.
// Reads are write-first: they return the state as it stands after the current edge.
module rf_multiport #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic              wr0_ok;
  logic              wr1_ok;
  logic              alloc_ok;

  logic [ADDR_W-1:0] ra       [NUM_RD];
  logic [DATA_W-1:0] rd_val_c [NUM_RD];

  // Entry 0 is hardwired to zero when ZERO_REG is set.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective write/alloc qualifiers; wr1 wins over wr0 on an address collision.
  always_comb begin
    wr1_ok   = wr1_en && !is_zero(wr1_addr);
    wr0_ok   = wr0_en && !is_zero(wr0_addr) && !(wr1_ok && (wr1_addr == wr0_addr));
    alloc_ok = alloc_en && !is_zero(alloc_addr);
  end

  // Next busy vector: writes retire an entry, an alloc at the same edge re-marks it.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok)   busy_nxt[wr0_addr]   = 1'b0;
    if (wr1_ok)   busy_nxt[wr1_addr]   = 1'b0;
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
  end

  // Split the packed read address bus into one address per port.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Per-port write-first read value: forward same-edge write data over the array.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val_c[i] = mem[ra[i]];
      if (wr0_ok && (wr0_addr == ra[i])) rd_val_c[i] = wr0_data;
      if (wr1_ok && (wr1_addr == ra[i])) rd_val_c[i] = wr1_data;
    end
  end

  // Storage array and busy scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
      busy <= busy_nxt;
    end
  end

  // Registered read ports; a disabled port holds its last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= rd_val_c[i];
          rd_busy[i]                  <= busy_nxt[ra[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: two instances (16-bit/2-port and
// 32-bit/4-port) driven by the same stimulus and compared to one array model.
module tb_rf_multiport;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_en;
  logic [15:0] rd_addr;
  logic        wr0_en, wr1_en, alloc_en;
  logic [3:0]  wr0_addr, wr1_addr, alloc_addr;
  logic [31:0] wr0_data, wr1_data;

  logic [31:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_busy_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: 32-bit entries; the 16-bit instance sees the low half.
  logic [31:0] m_mem  [16];
  logic        m_busy [16];
  logic [31:0] e_data [4];
  logic        e_busy [4];

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(16), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en[1:0]), .rd_addr(rd_addr[7:0]),
    .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data[15:0]),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data[15:0]),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  rf_multiport #(.DATA_W(32), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge to the model: reset, then writes in port order
  // (wr1 last, so it wins), then allocs, then reads see the updated state.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        e_data[p] = '0;
        e_busy[p] = 1'b0;
      end
    end else begin
      if (wr0_en && wr0_addr != 0) begin
        m_mem[wr0_addr]  = wr0_data;
        m_busy[wr0_addr] = 1'b0;
      end
      if (wr1_en && wr1_addr != 0) begin
        m_mem[wr1_addr]  = wr1_data;
        m_busy[wr1_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        if (rd_en[p]) begin
          e_data[p] = m_mem[rd_addr[p*AW +: AW]];
          e_busy[p] = m_busy[rd_addr[p*AW +: AW]];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < 2; p++) begin
      check($sformatf("a_data%0d", p), 32'(rd_data_a[p*16 +: 16]), 32'(e_data[p][15:0]));
      check($sformatf("a_busy%0d", p), 32'(rd_busy_a[p]), 32'(e_busy[p]));
    end
    for (int p = 0; p < 4; p++) begin
      check($sformatf("b_data%0d", p), rd_data_b[p*32 +: 32], e_data[p]);
      check($sformatf("b_busy%0d", p), 32'(rd_busy_b[p]), 32'(e_busy[p]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst_n    = 1'b1;
    rd_en    = '0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    alloc_en = 1'b0;
  endtask

  task automatic read_all(input logic [3:0] a);
    rd_en   = 4'hF;
    rd_addr = {a, a, a, a};
  endtask

  initial begin
    idle();
    rst_n      = 1'b0;
    rd_addr    = '0;
    wr0_addr   = '0; wr1_addr = '0; alloc_addr = '0;
    wr0_data   = '0; wr1_data = '0;
    cycle();
    cycle();
    check("rst_a_data", rd_data_a, 32'h0);
    check("rst_b_busy", 32'(rd_busy_b), 32'h0);

    // Every entry reads zero and not busy after reset.
    idle();
    for (int a = 1; a < 16; a++) begin
      read_all(4'(a));
      cycle();
      check("post_rst_zero", 32'(rd_data_a[15:0]), 32'h0);
    end

    // Same-cycle write and read of entry 3 returns the new value.
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h5A5A_BEEF;
    rd_en = 4'b0001; rd_addr = 16'h0003;
    cycle();
    check("wf_beef", 32'(rd_data_a[15:0]), 32'h0000_BEEF);
    idle();
    read_all(4'd3);
    cycle();
    check("later_beef", rd_data_b[63:32], 32'h5A5A_BEEF);

    // Write collision: wr1 wins.
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 32'h2222;
    cycle();
    idle();
    read_all(4'd5);
    cycle();
    check("collision", 32'(rd_data_a[31:16]), 32'h2222);

    // Scoreboard: alloc sets busy, a later write clears it.
    idle();
    alloc_en = 1'b1; alloc_addr = 4'd7;
    cycle();
    idle();
    read_all(4'd7);
    cycle();
    check("alloc_busy", 32'(rd_busy_a[0]), 32'h1);
    idle();
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h00A5;
    read_all(4'd7);
    cycle();
    check("wr_clears_busy", 32'(rd_busy_b[3]), 32'h0);
    check("wr_data_a5", 32'(rd_data_a[15:0]), 32'h00A5);

    // Alloc and write to the same entry: busy stays set, data stored.
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 32'h0BAD_F00D;
    alloc_en = 1'b1; alloc_addr = 4'd4;
    read_all(4'd4);
    cycle();
    check("alloc_wins_busy", 32'(rd_busy_b[1]), 32'h1);
    check("alloc_wr_data", rd_data_b[31:0], 32'h0BAD_F00D);

    // Entry 0 ignores writes and allocs.
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = 4'd0;
    cycle();
    idle();
    read_all(4'd0);
    cycle();
    check("zero_data", rd_data_b[127:96], 32'h0);
    check("zero_busy", 32'(rd_busy_a), 32'h0);

    // Disabled ports hold while addresses and contents change.
    idle();
    rd_addr = 16'h9876;
    wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 32'h7777;
    cycle();
    check("hold_a", 32'(rd_data_a[15:0]), 32'h0);

    // Reset with a simultaneous write discards it.
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h0000_1234;
    cycle();
    idle();
    rst_n = 1'b0;
    wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 32'h0000_4321;
    read_all(4'd9);
    cycle();
    idle();
    read_all(4'd9);
    cycle();
    check("rst_discards_a", 32'(rd_data_a[15:0]), 32'h0);
    check("rst_discards_b", rd_data_b[95:64], 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      rd_en      = 4'($urandom);
      rd_addr    = 16'($urandom);
      wr0_en     = 1'($urandom);
      wr0_addr   = 4'($urandom);
      wr0_data   = $urandom;
      wr1_en     = 1'($urandom);
      wr1_addr   = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom);
      wr1_data   = $urandom;
      alloc_en   = 1'($urandom);
      alloc_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
